vga_sync_monitor: RTL and testbench

//  Receive-side checker for the VGA timing the display controller drives: samples hSync/vSync/bright
//  on board_clk and recovers pixel/line coordinates from the sync edges alone.

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/sync_edge_det.sv | 40 ++++
 rtl/vga_sync_monitor.sv | 168 ++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_timing_pkg : 640x480@60 timing defaults shared with the display      |
// |                  controller, plus sync-monitor FSM encodings.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package vga_timing_pkg;

  localparam int H_TOTAL_DEF = 800;
  localparam int H_SYNC_DEF  = 96;
  localparam int V_TOTAL_DEF = 525;
  localparam logic SYNC_ACT_DEF = 1'b0;

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [10:0] CNT_MAX = 11'h7FF;

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == CNT_MAX) ? v : v + 11'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_edge_det : 2-flop synchroniser with leading/trailing edge pulses.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sync_edge_det #(
  parameter logic ACT = 1'b0
) (
  input  logic board_clk,
  input  logic Reset,
  input  logic i_async,
  output logic o_active,
  output logic o_lead,
  output logic o_trail
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Flops reset to the inactive level so release never fakes an edge
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      r_meta <= ~ACT;
      r_sync <= ~ACT;
      r_prev <= ~ACT;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_active = (r_sync == ACT);
  assign o_lead   = o_active && (r_prev != ACT);
  assign o_trail  = !o_active && (r_prev == ACT);

endmodule
`default_nettype wire

// File: rtl/vga_sync_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_sync_monitor : recovers VGA coordinates from sync edges, measures    |
// |                    line/frame timing and declares lock.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vga_sync_monitor
  import vga_timing_pkg::*;
#(
  parameter int   H_TOTAL     = H_TOTAL_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   V_TOTAL     = V_TOTAL_DEF,
  parameter logic SYNC_ACT    = SYNC_ACT_DEF,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic        board_clk,
  input  logic        Reset,
  input  logic        pix_ce,
  input  logic        hSync,
  input  logic        vSync,
  input  logic        bright,
  output logic [9:0]  rx_hc,
  output logic [9:0]  rx_vc,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [7:0]  hsync_w,
  output logic [10:0] frame_len,
  output logic        frame_stb,
  output logic        err_stb,
  output logic [7:0]  err_count
);

  localparam logic [10:0] c_H_TOTAL = 11'(H_TOTAL);
  localparam logic [7:0]  c_H_SYNC  = 8'(H_SYNC);
  localparam logic [10:0] c_V_TOTAL = 11'(V_TOTAL);
  localparam logic [3:0]  c_LOCK    = 4'(LOCK_FRAMES);

  logic w_h_act, w_h_lead, w_h_trail;
  logic w_v_act, w_v_lead, w_v_trail_unused;
  logic w_b_act, w_b_lead_unused, w_b_trail_unused;

  sync_edge_det #(.ACT(SYNC_ACT)) u_hs (
    .board_clk(board_clk), .Reset(Reset), .i_async(hSync),
    .o_active(w_h_act), .o_lead(w_h_lead), .o_trail(w_h_trail));
  sync_edge_det #(.ACT(SYNC_ACT)) u_vs (
    .board_clk(board_clk), .Reset(Reset), .i_async(vSync),
    .o_active(w_v_act), .o_lead(w_v_lead), .o_trail(w_v_trail_unused));
  sync_edge_det #(.ACT(1'b1)) u_br (
    .board_clk(board_clk), .Reset(Reset), .i_async(bright),
    .o_active(w_b_act), .o_lead(w_b_lead_unused), .o_trail(w_b_trail_unused));

  logic [10:0] r_hcnt, r_vcnt, r_line_len, r_frame_len;
  logic [7:0]  r_wcnt, r_hsync_w, r_err_count;
  logic [1:0]  r_state;
  logic [3:0]  r_good;
  logic        r_line_armed, r_frame_bad, r_blank_hit, r_frame_stb, r_err_stb;

  logic w_checking, w_sat_viol, w_line_viol, w_frame_viol, w_blank_raw, w_blank_viol, w_viol;

  assign w_checking   = (r_state != ST_SEARCH);
  // Fires once, on the pixel that drives the H counter into saturation
  assign w_sat_viol   = pix_ce && !w_h_lead && (r_hcnt == CNT_MAX - 11'd1);
  assign w_line_viol  = w_checking && w_h_lead && r_line_armed &&
                        ((r_hcnt != c_H_TOTAL) || (r_hsync_w != c_H_SYNC));
  assign w_frame_viol = w_checking && w_v_lead && (r_vcnt != c_V_TOTAL);
  assign w_blank_raw  = w_b_act && (w_h_act || w_v_act);
  assign w_blank_viol = w_checking && w_blank_raw && (!r_blank_hit || w_h_lead);
  assign w_viol       = w_sat_viol || w_line_viol || w_frame_viol || w_blank_viol;

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      r_hcnt       <= '0;
      r_vcnt       <= '0;
      r_line_len   <= '0;
      r_frame_len  <= '0;
      r_wcnt       <= '0;
      r_hsync_w    <= '0;
      r_err_count  <= '0;
      r_line_armed <= 1'b0;
      r_blank_hit  <= 1'b0;
      r_frame_stb  <= 1'b0;
      r_err_stb    <= 1'b0;
    end else begin
      if (w_h_lead) begin
        r_line_len <= r_hcnt;
        r_hcnt     <= '0;
      end else if (pix_ce) begin
        r_hcnt <= sat_inc11(r_hcnt);
      end

      if (w_h_trail) begin
        r_hsync_w <= r_wcnt;
        r_wcnt    <= '0;
      end else if (w_h_act && pix_ce && (r_wcnt != 8'hFF)) begin
        r_wcnt <= r_wcnt + 8'd1;
      end

      // A coincident vSync edge takes priority and drops the line count
      if (w_v_lead) begin
        r_frame_len <= r_vcnt;
        r_vcnt      <= '0;
      end else if (w_h_lead) begin
        r_vcnt <= sat_inc11(r_vcnt);
      end

      if (!w_checking)   r_line_armed <= 1'b0;
      else if (w_h_lead) r_line_armed <= 1'b1;

      if (w_h_lead)         r_blank_hit <= w_blank_raw;
      else if (w_blank_raw) r_blank_hit <= 1'b1;

      r_frame_stb <= w_v_lead;
      r_err_stb   <= w_viol;
      if (w_viol && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
    end
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_SEARCH;
      r_good      <= '0;
      r_frame_bad <= 1'b0;
    end else begin
      case (r_state)
        ST_SEARCH: begin
          if (w_v_lead) begin
            r_state     <= ST_MEASURE;
            r_good      <= '0;
            r_frame_bad <= 1'b0;
          end
        end
        ST_MEASURE: begin
          if (w_sat_viol) begin
            r_state <= ST_SEARCH;
          end else if (w_v_lead) begin
            r_frame_bad <= 1'b0;
            if (w_viol || r_frame_bad) begin
              r_good <= '0;
            end else begin
              r_good <= r_good + 4'd1;
              if (r_good + 4'd1 == c_LOCK) r_state <= ST_LOCKED;
            end
          end else if (w_viol) begin
            r_frame_bad <= 1'b1;
            r_good      <= '0;
          end
        end
        ST_LOCKED: begin
          if (w_viol) r_state <= ST_SEARCH;
        end
        default: r_state <= ST_SEARCH;
      endcase
    end
  end

  assign rx_hc     = r_hcnt[9:0];
  assign rx_vc     = r_vcnt[9:0];
  assign locked    = (r_state == ST_LOCKED);
  assign line_len  = r_line_len;
  assign hsync_w   = r_hsync_w;
  assign frame_len = r_frame_len;
  assign frame_stb = r_frame_stb;
  assign err_stb   = r_err_stb;
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_sync_monitor : directed self-checking bench on a scaled timing    |
// |                       (40 px/line, 6 px hSync, 12 lines/frame).          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_vga_sync_monitor;

  localparam int HT     = 40;
  localparam int HS     = 6;
  localparam int VT     = 12;
  localparam int HSTART = 32;
  localparam int HVIS   = 30;

  logic        board_clk = 1'b0;
  logic        Reset     = 1'b1;
  logic        pix_ce    = 1'b0;
  logic        hSync     = 1'b1;
  logic        vSync     = 1'b1;
  logic        bright    = 1'b0;
  logic [9:0]  rx_hc, rx_vc;
  logic        locked, frame_stb, err_stb;
  logic [10:0] line_len, frame_len;
  logic [7:0]  hsync_w, err_count;

  vga_sync_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .SYNC_ACT(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .board_clk(board_clk), .Reset(Reset), .pix_ce(pix_ce),
    .hSync(hSync), .vSync(vSync), .bright(bright),
    .rx_hc(rx_hc), .rx_vc(rx_vc), .locked(locked),
    .line_len(line_len), .hsync_w(hsync_w), .frame_len(frame_len),
    .frame_stb(frame_stb), .err_stb(err_stb), .err_count(err_count)
  );

  always #5 board_clk = ~board_clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   stb_cnt = 0;
  int   pulse_cnt = 0;
  logic stb_locked = 1'b0;

  always @(negedge board_clk) begin
    if (frame_stb) begin
      stb_cnt    = stb_cnt + 1;
      stb_locked = locked;
    end
    if (err_stb) pulse_cnt = pulse_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pixel(input logic h, input logic v, input logic b);
    @(posedge board_clk); #1;
    pix_ce = 1'b1; hSync = h; vSync = v; bright = b;
    @(posedge board_clk); #1;
    pix_ce = 1'b0;
    repeat (2) @(posedge board_clk);
  endtask

  // Line layout: visible 0..29, hSync active 32..37; vSync active on lines 0..1
  task automatic drive_line(input int vc, input int extra, input logic bad_bright);
    for (int hc = 0; hc < HT + extra; hc++) begin
      logic hact;
      hact = (hc >= HSTART) && (hc < HSTART + HS);
      pixel(!hact, !(vc < 2), ((hc < HVIS) && (vc >= 2)) || (bad_bright && hact));
    end
  endtask

  // kind 0: clean, 1: line 5 one pixel long, 2: bright during hSync on line 5
  task automatic drive_frame(input int kind);
    for (int vc = 0; vc < VT; vc++)
      drive_line(vc, (kind == 1 && vc == 5) ? 1 : 0, (kind == 2 && vc == 5));
  endtask

  typedef struct {
    int kind;
    int e_stb_lock;
    int e_locked;
    int e_err;
    int e_pulses;
    int e_flen;
  } vec_t;

  task automatic run_frame(input string tag, input vec_t v);
    int s0, p0;
    s0 = stb_cnt;
    p0 = pulse_cnt;
    drive_frame(v.kind);
    @(negedge board_clk);
    check({tag, ".frame_stb_count"}, stb_cnt - s0, 1);
    check({tag, ".locked_at_vsync"}, int'(stb_locked), v.e_stb_lock);
    check({tag, ".locked_end"}, int'(locked), v.e_locked);
    check({tag, ".err_count"}, int'(err_count), v.e_err);
    check({tag, ".err_pulses"}, pulse_cnt - p0, v.e_pulses);
    check({tag, ".frame_len"}, int'(frame_len), v.e_flen);
    check({tag, ".line_len"}, int'(line_len), HT);
    check({tag, ".hsync_w"}, int'(hsync_w), HS);
  endtask

  vec_t vecs[11];
  vec_t relock[3];
  vec_t postrst[3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    vecs[0]  = '{0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, VT};
    vecs[2]  = '{0, 1, 1, 0, 0, VT};
    vecs[3]  = '{1, 1, 0, 1, 1, VT};
    vecs[4]  = '{0, 0, 0, 1, 0, VT};
    vecs[5]  = '{0, 0, 0, 1, 0, VT};
    vecs[6]  = '{0, 1, 1, 1, 0, VT};
    vecs[7]  = '{2, 1, 0, 2, 1, VT};
    vecs[8]  = '{0, 0, 0, 2, 0, VT};
    vecs[9]  = '{0, 0, 0, 2, 0, VT};
    vecs[10] = '{0, 1, 1, 2, 0, VT};
    relock[0]  = '{0, 0, 0, 3, 0, VT};
    relock[1]  = '{0, 0, 0, 3, 0, VT};
    relock[2]  = '{0, 1, 1, 3, 0, VT};
    postrst[0] = '{0, 0, 0, 0, 0, 0};
    postrst[1] = '{0, 0, 0, 0, 0, VT};
    postrst[2] = '{0, 1, 1, 0, 0, VT};

    repeat (4) @(posedge board_clk);
    @(negedge board_clk);
    check("reset.outputs", int'({rx_hc, rx_vc, locked, line_len, hsync_w,
                                 frame_len, frame_stb, err_stb, err_count}), 0);
    @(posedge board_clk); #1;
    Reset = 1'b0;

    for (int i = 0; i < 11; i++) run_frame($sformatf("vec%0d", i), vecs[i]);

    // Loss of sync while locked: 2100 pixels with no hSync
    p0 = pulse_cnt;
    repeat (2100) pixel(1'b1, 1'b1, 1'b0);
    @(negedge board_clk);
    check("sat.rx_hc", int'(rx_hc), 2047 & 10'h3FF);
    check("sat.locked", int'(locked), 0);
    check("sat.err_count", int'(err_count), 3);
    check("sat.err_pulses", pulse_cnt - p0, 1);
    for (int i = 0; i < 3; i++) run_frame($sformatf("relock%0d", i), relock[i]);

    // Reset partway through a locked frame
    for (int vc = 0; vc < 5; vc++) drive_line(vc, 0, 1'b0);
    @(posedge board_clk); #2;
    Reset = 1'b1;
    #1;
    check("midreset.outputs", int'({rx_hc, rx_vc, locked, line_len, hsync_w,
                                    frame_len, frame_stb, err_stb, err_count}), 0);
    repeat (3) @(posedge board_clk);
    #1;
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) run_frame($sformatf("postrst%0d", i), postrst[i]);

    // 300 short-line violations while in MEASURE: err_count saturates, pulses continue
    @(posedge board_clk); #1;
    Reset = 1'b1;
    repeat (2) @(posedge board_clk);
    #1;
    Reset = 1'b0;
    repeat (3) pixel(1'b1, 1'b0, 1'b0);
    p0 = pulse_cnt;
    for (int i = 0; i < 301; i++) begin
      pixel(1'b0, 1'b0, 1'b0);
      pixel(1'b1, 1'b0, 1'b0);
    end
    repeat (6) @(posedge board_clk);
    @(negedge board_clk);
    check("burst.err_count", int'(err_count), 255);
    check("burst.err_pulses", pulse_cnt - p0, 300);
    check("burst.line_len", int'(line_len), 2);
    check("burst.hsync_w", int'(hsync_w), 1);
    check("burst.locked", int'(locked), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
